// File: rtl/fpdiv_pkg.sv
// rtl/fpdiv_pkg.sv - shared state and mux-select encodings for the fpdiv datapath and its controller
package fpdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_N,
    S_INIT_D,
    S_ITER_N,
    S_ITER_D,
    S_REM_Q,
    S_REM_M,
    S_DONE
  } state_t;

  // multiplier operand source
  localparam logic [1:0] SEL3_IA = 2'b00;
  localparam logic [1:0] SEL3_C  = 2'b01;
  localparam logic [1:0] SEL3_Q  = 2'b10;

  // product routing into the numerator/denominator/remainder paths
  localparam logic [2:0] SEL5_N_IA   = 3'b000;
  localparam logic [2:0] SEL5_D_IA   = 3'b001;
  localparam logic [2:0] SEL5_N_PATH = 3'b010;
  localparam logic [2:0] SEL5_D_PATH = 3'b011;
  localparam logic [2:0] SEL5_MQ_D   = 3'b100;

endpackage

// File: rtl/fpdiv_ctrl_if.sv
// rtl/fpdiv_ctrl_if.sv - request and control-select bundle between requester, sequencer and fpdiv
interface fpdiv_ctrl_if;

  logic       start;
  logic       rm_in;
  logic       rm;
  logic [1:0] sel_mux3;
  logic [2:0] sel_mux5;
  logic       en_a;
  logic       en_b;
  logic       en_rem;
  logic       busy;
  logic       done;

  modport master (
    output start, rm_in,
    input  rm, sel_mux3, sel_mux5, en_a, en_b, en_rem, busy, done
  );

  modport slave (
    input  start, rm_in,
    output rm, sel_mux3, sel_mux5, en_a, en_b, en_rem, busy, done
  );

endinterface

// File: rtl/fpdiv_ctrl.sv
// rtl/fpdiv_ctrl.sv - Goldschmidt divider sequencer: IA multiply, ITER-1 refinements, q*D remainder
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int ITER = 6
) (
  input  logic         clk,
  input  logic         reset,
  fpdiv_ctrl_if.slave  bus
);

  localparam int            CW     = $clog2(ITER + 1);
  localparam logic [CW-1:0] ITER_C = CW'(ITER);
  localparam logic [CW-1:0] CNT_0  = CW'(2);

  state_t        state, state_nxt;
  logic [CW-1:0] iter_cnt, cnt_nxt;
  logic          rm_q;

  logic [1:0] sel3;
  logic [2:0] sel5;
  logic       en_a, en_b, en_rem, busy, done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      rm_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= cnt_nxt;
      // rounding mode is captured only on an accepted start and frozen otherwise
      if (state == S_IDLE && bus.start)
        rm_q <= bus.rm_in;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = iter_cnt;
    sel3      = SEL3_IA;
    sel5      = SEL5_N_IA;
    en_a      = 1'b0;
    en_b      = 1'b0;
    en_rem    = 1'b0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (bus.start)
          state_nxt = S_INIT_N;
      end
      S_INIT_N: begin
        sel5      = SEL5_N_IA;
        sel3      = SEL3_IA;
        en_a      = 1'b1;
        state_nxt = S_INIT_D;
      end
      S_INIT_D: begin
        sel5      = SEL5_D_IA;
        sel3      = SEL3_IA;
        en_b      = 1'b1;
        cnt_nxt   = CNT_0;
        state_nxt = S_ITER_N;
      end
      S_ITER_N: begin
        sel5      = SEL5_N_PATH;
        sel3      = SEL3_C;
        en_a      = 1'b1;
        state_nxt = S_ITER_D;
      end
      S_ITER_D: begin
        sel5 = SEL5_D_PATH;
        sel3 = SEL3_C;
        en_b = 1'b1;
        if (iter_cnt == ITER_C) begin
          state_nxt = S_REM_Q;
        end else begin
          cnt_nxt   = iter_cnt + 1'b1;
          state_nxt = S_ITER_N;
        end
      end
      S_REM_Q: begin
        sel5      = SEL5_N_PATH;
        sel3      = SEL3_Q;
        en_rem    = 1'b1;
        state_nxt = S_REM_M;
      end
      S_REM_M: begin
        sel5      = SEL5_MQ_D;
        sel3      = SEL3_Q;
        en_rem    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.rm       = rm_q;
  assign bus.sel_mux3 = sel3;
  assign bus.sel_mux5 = sel5;
  assign bus.en_a     = en_a;
  assign bus.en_b     = en_b;
  assign bus.en_rem   = en_rem;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule
